pulse_monitor: RTL and testbench
================================

# pulse_monitor

Receive-side checker for the divided-clock `go` strobe produced by the lab 7 pulse generator. It measures the number of clock cycles between successive `go` pulses and reports each measured period. It compares every period against an expected divide ratio and counts received pulses. Results are shown on the board LEDs, and the block sits beside the generator to self-check the divider on hardware and in simulation.

## Interface
Parameters:
- CW, 7: period counter width; saturation/timeout value is 2^CW-1 = 127.

Ports:
- clock  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high; clears all state and outputs on the next posedge.
- enable  input  1  1 = monitor active; 0 = idle, go ignored.
- go  input  1  pulse stream under test, sampled every posedge; each cycle sampled high is one pulse.
- expected  input  6  expected period in cycles; 0 disables comparison.
- period  output  CW  last measured period.
- valid  output  1  one-cycle strobe, high the cycle after a new `period` is loaded.
- mismatch  output  1  sticky; set when a measured period is not equal to `expected` (expected != 0).
- timeout  output  1  sticky; set when no pulse arrives within 127 cycles while measuring.
- pulse_count  output  8  pulses received while enabled, wraps 255 -> 0.
- LEDR  output  10  {timeout, mismatch, pulse_count[7:0]}.

## Operation
- State machine with states IDLE, ARM, MEASURE; reset -> IDLE.
- IDLE:
  - cnt is held at 0.
  - enable=1 -> ARM on the next edge; otherwise stay.
- ARM (waiting for the first pulse, no timeout):
  - go=1 -> cnt<=1, pulse_count+1, -> MEASURE.
  - No period is produced for this first pulse.
- MEASURE, go=1:
  - period<=cnt, valid<=1, cnt<=1, pulse_count+1.
  - If expected!=0 and cnt != {0,expected}, mismatch<=1.
- MEASURE, go=0, cnt<127: cnt<=cnt+1.
- MEASURE, go=0, cnt==127: timeout<=1, cnt<=0, -> ARM.
- enable=0 in any state: -> IDLE on the next edge and cnt<=0.
  - go is ignored that cycle.
  - period, mismatch, timeout and pulse_count hold.
  - valid<=0.
- Re-enable always restarts from ARM, so the first pulse after re-enable is never measured.
- Continuous go=1 in MEASURE yields period=1 every cycle, with valid high continuously.
- pulse_count is 8-bit unsigned and wraps modulo 256. The comparison zero-extends `expected` to CW bits.
- mismatch and timeout clear only on reset.

## Timing
- Reset values: period=0, valid=0, mismatch=0, timeout=0, pulse_count=0, LEDR=0, state=IDLE, cnt=0.
- All outputs are registered; none is combinational from inputs.
- Latency:
  - go sampled high at edge N gives period/valid/mismatch/pulse_count updated after edge N, visible in cycle N+1.
  - valid is high for exactly that one cycle unless go is also high at edge N+1.
- Period definition: go high at edges N and N+P (no go in between) gives period=P.
- enable rising at edge E: state=ARM after E; a go sampled at E+1 is the first counted pulse.
- Reset has priority over enable and go in the same cycle.
  - Reset mid-MEASURE discards the partial count.
  - After reset deasserts, the block sits in IDLE for one edge before ARM, even with enable=1.
- go=1 and cnt==127 on the same edge: the pulse wins; period=127 is loaded and there is no timeout.

## Test plan
- Divide-by-2: expected=2, enable=1, go high every 2nd cycle for 10 pulses.
  - Required: first valid after the 2nd pulse, period=2 on 9 strobes, mismatch=0, pulse_count=10, LEDR=10'h00A.
- Divide-by-3 then mismatch: expected=3, 20 pulses at spacing 3, then one gap of 4.
  - Required: period=3 on 19 strobes, then period=4 with mismatch=1; mismatch stays 1 on the following spacing-3 pulses.
- Timeout: expected=5, two pulses 5 apart, then go held 0 for 130 cycles.
  - Required: timeout=1 exactly 127 cycles after the last pulse, state returns to ARM, and the next pulse gives no valid.
- Boundary:
  - go held high continuously: period=1, valid high every cycle after the 2nd pulse.
  - Pulses 127 apart: period=127, no timeout.
  - expected=0 with random spacing: mismatch never set.
- Enable/reset mid-operation:
  - enable dropped mid-MEASURE: outputs hold and go is ignored.
  - After re-enable, the first pulse gives no valid.
  - reset asserted with mismatch=1, pulse_count=37: all outputs 0 after one edge.
- Wrap: 257 pulses at spacing 2 gives pulse_count=1 and LEDR[7:0]=8'h01.

Source files
------------

// File: rtl/pulse_monitor_if.sv
// pulse_monitor_if: signal bundle between the pulse generator side and the
// pulse monitor.
//   enable      - monitor active (1) / idle (0)
//   go          - pulse stream under test
//   expected    - expected period in cycles, 0 disables comparison
//   period      - last measured period (CW bits)
//   valid       - one-cycle strobe after a new period is loaded
//   mismatch    - sticky period-compare failure flag
//   timeout     - sticky no-pulse-within-limit flag
//   pulse_count - pulses received while enabled, wraps modulo 256
//   LEDR        - board LEDs {timeout, mismatch, pulse_count}
// master drives the stimulus side, slave is the monitor itself.
interface pulse_monitor_if #(
   parameter int unsigned CW = 7
);
   logic          enable;
   logic          go;
   logic [5:0]    expected;
   logic [CW-1:0] period;
   logic          valid;
   logic          mismatch;
   logic          timeout;
   logic [7:0]    pulse_count;
   logic [9:0]    LEDR;

   modport master (
      output enable, go, expected,
      input  period, valid, mismatch, timeout, pulse_count, LEDR
   );

   modport slave (
      input  enable, go, expected,
      output period, valid, mismatch, timeout, pulse_count, LEDR
   );
endinterface

// File: rtl/pulse_monitor.sv
// pulse_monitor: receive-side checker for the divided-clock go strobe.
// Measures the cycle count between successive go pulses, compares each
// period against an expected divide ratio, counts pulses and flags a
// missing pulse after 2^CW-1 cycles.
// Ports:
//   clock - system clock, all logic on posedge
//   reset - synchronous active-high reset, clears all state and outputs
//   bus   - pulse_monitor_if slave modport (enable/go/expected in,
//           period/valid/mismatch/timeout/pulse_count/LEDR out)
module pulse_monitor #(
   parameter int unsigned CW = 7
) (
   input  logic          clock,
   input  logic          reset,
   pulse_monitor_if.slave bus
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] ARM     = 2'd1;
   localparam logic [1:0] MEASURE = 2'd2;

   localparam logic [CW-1:0] CNT_MAX = '1;
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] period_q;
   logic          valid_q;
   logic          mismatch_q;
   logic          timeout_q;
   logic [7:0]    pulse_count_q;
   logic [CW-1:0] expected_ext;

   assign expected_ext = CW'(bus.expected);

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         period_q      <= '0;
         valid_q       <= 1'b0;
         mismatch_q    <= 1'b0;
         timeout_q     <= 1'b0;
         pulse_count_q <= '0;
      end else if (!bus.enable) begin
         // go is ignored while disabled; results and sticky flags hold
         state   <= IDLE;
         cnt     <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state)
            IDLE: begin
               cnt   <= '0;
               state <= ARM;
            end
            ARM: begin
               // first pulse only starts the measurement, no period yet
               if (bus.go) begin
                  cnt           <= CNT_ONE;
                  pulse_count_q <= pulse_count_q + 8'd1;
                  state         <= MEASURE;
               end
            end
            MEASURE: begin
               // a pulse on the saturation cycle still wins over timeout
               if (bus.go) begin
                  period_q      <= cnt;
                  valid_q       <= 1'b1;
                  cnt           <= CNT_ONE;
                  pulse_count_q <= pulse_count_q + 8'd1;
                  if ((bus.expected != 6'd0) && (cnt != expected_ext)) begin
                     mismatch_q <= 1'b1;
                  end
               end else if (cnt == CNT_MAX) begin
                  timeout_q <= 1'b1;
                  cnt       <= '0;
                  state     <= ARM;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   assign bus.period      = period_q;
   assign bus.valid       = valid_q;
   assign bus.mismatch    = mismatch_q;
   assign bus.timeout     = timeout_q;
   assign bus.pulse_count = pulse_count_q;
   assign bus.LEDR        = {timeout_q, mismatch_q, pulse_count_q};

endmodule

// File: tb/tb_pulse_monitor.sv
module tb_pulse_monitor;

   localparam int unsigned CW = 7;

   logic clock = 1'b0;
   logic reset;

   pulse_monitor_if #(.CW(CW)) bus();

   pulse_monitor #(.CW(CW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // ---------------- reference model (timestamp based) ----------------
   int   m_now;
   bit   m_active;     // has spent one enabled edge since idle
   bit   m_have_ref;   // a reference pulse exists to measure from
   int   m_ref;        // edge number of last pulse
   int   m_period;
   bit   m_valid, m_mm, m_to;
   int   m_pc;

   task automatic model_step(input bit rst, input bit en, input bit go, input int exp);
      int gap;
      m_now++;
      if (rst) begin
         m_active = 0; m_have_ref = 0; m_period = 0;
         m_valid = 0; m_mm = 0; m_to = 0; m_pc = 0;
      end else if (!en) begin
         m_active = 0; m_have_ref = 0; m_valid = 0;
      end else if (!m_active) begin
         m_active = 1; m_valid = 0;
      end else if (!m_have_ref) begin
         m_valid = 0;
         if (go) begin
            m_have_ref = 1; m_ref = m_now; m_pc = (m_pc + 1) % 256;
         end
      end else begin
         gap = m_now - m_ref;
         if (go) begin
            m_period = gap; m_valid = 1;
            if (exp != 0 && gap != exp) m_mm = 1;
            m_ref = m_now; m_pc = (m_pc + 1) % 256;
         end else begin
            m_valid = 0;
            if (gap >= 127) begin
               m_to = 1; m_have_ref = 0;
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s at t=%0t: got=%0h want=%0h", name, $time, got, want);
      end
   endtask

   task automatic model_check();
      chk("m_period",   32'(bus.period),      32'(m_period));
      chk("m_valid",    32'(bus.valid),       32'(m_valid));
      chk("m_mismatch", 32'(bus.mismatch),    32'(m_mm));
      chk("m_timeout",  32'(bus.timeout),     32'(m_to));
      chk("m_count",    32'(bus.pulse_count), 32'(m_pc));
      chk("m_ledr",     32'(bus.LEDR),        {22'd0, m_to, m_mm, 8'(m_pc)});
   endtask

   // drive one cycle, advance the model, compare just after the edge
   task automatic apply(input bit rst, input bit en, input bit go, input int exp);
      reset        = rst;
      bus.enable   = en;
      bus.go       = go;
      bus.expected = 6'(exp);
      @(posedge clock);
      model_step(rst, en, go, exp);
      #1;
      model_check();
   endtask

   int strobes;
   int bad_period;

   task automatic count_strobe(input int want_p);
      if (bus.valid === 1'b1) begin
         strobes++;
         if (int'(bus.period) != want_p) bad_period++;
      end
   endtask

   // n pulses, go-high edges 'spacing' apart
   task automatic pulses(input int n, input int spacing, input int exp);
      for (int i = 0; i < n; i++) begin
         apply(0, 1, 1, exp);
         count_strobe(spacing);
         for (int j = 0; j < spacing - 1; j++) begin
            apply(0, 1, 0, exp);
            count_strobe(spacing);
         end
      end
   endtask

   task automatic restart(input int exp);
      apply(1, 0, 0, exp);
      apply(0, 1, 0, exp);   // IDLE -> ARM
      strobes = 0; bad_period = 0;
   endtask

   typedef struct {
      bit         rst, en, go;
      logic [5:0] exp;
      logic [6:0] period;
      bit         valid, mm, to;
      logic [7:0] pc;
   } vec_t;

   vec_t tbl[15];

   initial begin
      bit go_r, en_r, rst_r;
      int exp_r, mode;

      m_now = 0; m_active = 0; m_have_ref = 0; m_ref = 0;
      m_period = 0; m_valid = 0; m_mm = 0; m_to = 0; m_pc = 0;

      //           rst en go exp period v  mm to pc
      tbl[0]  = '{1, 0, 0, 2, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 1, 2, 0, 0, 0, 0, 0};   // IDLE->ARM, go ignored
      tbl[2]  = '{0, 1, 1, 2, 0, 0, 0, 0, 1};   // first pulse
      tbl[3]  = '{0, 1, 0, 2, 0, 0, 0, 0, 1};
      tbl[4]  = '{0, 1, 1, 2, 2, 1, 0, 0, 2};
      tbl[5]  = '{0, 1, 0, 2, 2, 0, 0, 0, 2};
      tbl[6]  = '{0, 1, 1, 2, 2, 1, 0, 0, 3};
      tbl[7]  = '{0, 1, 1, 2, 1, 1, 1, 0, 4};   // period 1 vs 2
      tbl[8]  = '{0, 0, 1, 2, 1, 0, 1, 0, 4};   // disabled: hold
      tbl[9]  = '{0, 1, 1, 2, 1, 0, 1, 0, 4};   // re-enable -> ARM
      tbl[10] = '{0, 1, 1, 2, 1, 0, 1, 0, 5};   // first pulse, no valid
      tbl[11] = '{0, 1, 0, 2, 1, 0, 1, 0, 5};
      tbl[12] = '{0, 1, 0, 2, 1, 0, 1, 0, 5};
      tbl[13] = '{0, 1, 1, 2, 3, 1, 1, 0, 6};
      tbl[14] = '{1, 1, 1, 2, 0, 0, 0, 0, 0};   // reset wins

      for (int i = 0; i < 15; i++) begin
         apply(tbl[i].rst, tbl[i].en, tbl[i].go, int'(tbl[i].exp));
         chk("t_period",   32'(bus.period),      32'(tbl[i].period));
         chk("t_valid",    32'(bus.valid),       32'(tbl[i].valid));
         chk("t_mismatch", 32'(bus.mismatch),    32'(tbl[i].mm));
         chk("t_timeout",  32'(bus.timeout),     32'(tbl[i].to));
         chk("t_count",    32'(bus.pulse_count), 32'(tbl[i].pc));
         chk("t_ledr",     32'(bus.LEDR),        {22'd0, tbl[i].to, tbl[i].mm, tbl[i].pc});
      end

      // divide-by-2
      restart(2);
      pulses(10, 2, 2);
      chk("div2_strobes",  32'(strobes), 32'd9);
      chk("div2_badper",   32'(bad_period), 32'd0);
      chk("div2_mismatch", 32'(bus.mismatch), 32'd0);
      chk("div2_count",    32'(bus.pulse_count), 32'd10);
      chk("div2_ledr",     32'(bus.LEDR), 32'h00A);

      // divide-by-3 then a gap of 4
      restart(3);
      pulses(20, 3, 3);
      chk("div3_strobes", 32'(strobes), 32'd19);
      chk("div3_badper",  32'(bad_period), 32'd0);
      chk("div3_mm0",     32'(bus.mismatch), 32'd0);
      apply(0, 1, 0, 3);
      apply(0, 1, 1, 3);
      chk("gap4_period", 32'(bus.period), 32'd4);
      chk("gap4_valid",  32'(bus.valid), 32'd1);
      chk("gap4_mm",     32'(bus.mismatch), 32'd1);
      apply(0, 1, 0, 3);
      apply(0, 1, 0, 3);
      pulses(3, 3, 3);
      chk("sticky_mm", 32'(bus.mismatch), 32'd1);

      // timeout 127 cycles after last pulse
      restart(5);
      pulses(2, 5, 5);    // second pulse followed by 4 idle edges
      for (int k = 5; k <= 130; k++) begin
         apply(0, 1, 0, 5);
         if (k == 126) chk("to_early", 32'(bus.timeout), 32'd0);
         if (k == 127) chk("to_exact", 32'(bus.timeout), 32'd1);
      end
      apply(0, 1, 1, 5);
      chk("to_rearm_valid", 32'(bus.valid), 32'd0);
      chk("to_rearm_count", 32'(bus.pulse_count), 32'd3);

      // pulses exactly 127 apart
      restart(0);
      apply(0, 1, 1, 0);
      for (int k = 0; k < 126; k++) apply(0, 1, 0, 0);
      apply(0, 1, 1, 0);
      chk("p127_period",  32'(bus.period), 32'd127);
      chk("p127_valid",   32'(bus.valid), 32'd1);
      chk("p127_timeout", 32'(bus.timeout), 32'd0);

      // go held high continuously
      restart(0);
      pulses(6, 1, 0);
      chk("cont_strobes", 32'(strobes), 32'd5);
      chk("cont_badper",  32'(bad_period), 32'd0);

      // mismatch + count 37, then reset clears everything
      restart(3);
      pulses(36, 3, 3);
      apply(0, 1, 0, 3);
      apply(0, 1, 1, 3);
      chk("pre_rst_mm",    32'(bus.mismatch), 32'd1);
      chk("pre_rst_count", 32'(bus.pulse_count), 32'd37);
      apply(1, 1, 1, 3);
      chk("rst_ledr",   32'(bus.LEDR), 32'd0);
      chk("rst_period", 32'(bus.period), 32'd0);
      apply(0, 1, 1, 3);   // still one IDLE edge after reset
      chk("post_rst_count", 32'(bus.pulse_count), 32'd0);

      // wrap of the pulse counter
      restart(2);
      pulses(257, 2, 2);
      chk("wrap_count", 32'(bus.pulse_count), 32'd1);
      chk("wrap_ledr",  32'(bus.LEDR[7:0]), 32'h01);

      // expected=0, random spacing: mismatch never set
      restart(0);
      for (int k = 0; k < 300; k++) begin
         apply(0, 1, ($urandom_range(0, 3) == 0), 0);
      end
      chk("exp0_mm", 32'(bus.mismatch), 32'd0);

      // fully randomised traffic against the model
      restart(0);
      mode = 0; exp_r = 0;
      for (int k = 0; k < 2000; k++) begin
         if (k % 100 == 0) begin
            mode  = int'($urandom_range(0, 3));
            exp_r = int'($urandom_range(0, 8));
         end
         case (mode)
            0:       go_r = ($urandom_range(0, 1) == 1);
            1:       go_r = ($urandom_range(0, 7) == 0);
            2:       go_r = ($urandom_range(0, 199) == 0);
            default: go_r = ($urandom_range(0, 2) == 0);
         endcase
         en_r  = ($urandom_range(0, 49) != 0);
         rst_r = ($urandom_range(0, 299) == 0);
         apply(rst_r, en_r, go_r, exp_r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
